gen2_boot_core_mctimer: RTL

//  Multi-channel interval timer on an Avalon-MM slave. Successor to the single 32-bit systimer.
//  NUM_CH independent down-counters, each CNT_W bits wide, with one-shot/continuous modes.

---
 rtl/gen2_boot_core_mctimer_pkg.sv | 19 +
 rtl/gen2_boot_core_mctimer_if.sv | 12 +
 rtl/gen2_boot_core_mctimer_channel.sv | 68 ++++++
 rtl/gen2_boot_core_mctimer.sv | 87 ++++++++
 4 files changed

// File: rtl/gen2_boot_core_mctimer_pkg.sv
// gen2_boot_core_mctimer_pkg: register map, bit positions and global-register placement for the multi-channel timer
package gen2_boot_core_mctimer_pkg;
    typedef enum logic [1:0] {
        OFF_STATUS  = 2'd0,
        OFF_CONTROL = 2'd1,
        OFF_PERIOD  = 2'd2,
        OFF_SNAP    = 2'd3
    } reg_off_e;
    localparam int CH_STRIDE = 4;
    localparam int ST_TO     = 0;
    localparam int ST_RUN    = 1;
    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;
    function automatic int glob_base(input int num_ch);
        return CH_STRIDE * num_ch;
    endfunction
endpackage

// File: rtl/gen2_boot_core_mctimer_if.sv
// gen2_boot_core_mctimer_if: Avalon-MM slave bus bundle for the multi-channel timer
interface gen2_boot_core_mctimer_if #(
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/gen2_boot_core_mctimer_channel.sv
// gen2_boot_core_mctimer_channel: one down-counter with period, control, timeout flag and snapshot
module gen2_boot_core_mctimer_channel
    import gen2_boot_core_mctimer_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 24999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr_status,
    input  logic             wr_control,
    input  logic             wr_period,
    input  logic             wr_snap,
    input  logic [CNT_W-1:0] wdata,
    input  logic [1:0]       rd_off,
    output logic [31:0]      rdata,
    output logic             pend
);
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
    logic [1:0]       ctrl_q, ctrl_d, status;
    logic             run_q, run_d, to_q, to_d, zero_q, zero_d, force_q, force_d;
    logic             expire, timeout;

    always_comb begin
        expire   = run_q & tick & (cnt_q == '0);
        // zero_q remembers last cycle's zero state so a counter parked at 0 raises only one timeout
        timeout  = (cnt_q == '0) & ~zero_q;
        zero_d   = cnt_q == '0;
        force_d  = wr_period;
        cnt_d    = force_q ? period_q : (run_q & tick) ? (expire ? period_q : cnt_q - CNT_W'(1)) : cnt_q;
        run_d    = (wr_control & wdata[CTL_START]) |
                   (run_q & ~(wr_control & wdata[CTL_STOP]) & ~force_q & ~(expire & ~ctrl_q[CTL_CONT]));
        ctrl_d   = wr_control ? wdata[1:0] : ctrl_q;
        period_d = wr_period ? wdata : period_q;
        snap_d   = wr_snap ? cnt_q : snap_q;
        to_d     = timeout | (to_q & ~wr_status);
        status         = '0;
        status[ST_RUN] = run_q;
        status[ST_TO]  = to_q;
        pend     = to_q & ctrl_q[CTL_ITO];
        rdata    = (rd_off == OFF_STATUS)  ? 32'(status) :
                   (rd_off == OFF_CONTROL) ? 32'(ctrl_q) :
                   (rd_off == OFF_PERIOD)  ? 32'(period_q) : 32'(snap_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= CNT_W'(RESET_PERIOD);
            period_q <= CNT_W'(RESET_PERIOD);
            snap_q   <= '0;
            ctrl_q   <= '0;
            run_q    <= 1'b0;
            to_q     <= 1'b0;
            zero_q   <= 1'b1;
            force_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            ctrl_q   <= ctrl_d;
            run_q    <= run_d;
            to_q     <= to_d;
            zero_q   <= zero_d;
            force_q  <= force_d;
        end
    end
endmodule

// File: rtl/gen2_boot_core_mctimer.sv
// gen2_boot_core_mctimer: multi-channel Avalon-MM interval timer with pending register and combined irq.
// Define GEN2_MCTIMER_PRESCALER_EN to add the shared PRESCALE tick divider.
module gen2_boot_core_mctimer
    import gen2_boot_core_mctimer_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 24999,
    parameter int PRESCALE_W   = 8,
    parameter int ADDR_W       = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    gen2_boot_core_mctimer_if.slave bus,
    output logic                   irq
);
    localparam int GLOB = glob_base(NUM_CH);

    logic              wr, tick;
    logic [NUM_CH-1:0] pend;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [31:0]       prescale_rd, rd_mux, readdata_q, readdata_d;

    assign wr = bus.chipselect & ~bus.write_n;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int BASE = CH_STRIDE * c;
        gen2_boot_core_mctimer_channel #(
            .CNT_W        (CNT_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .wr_status  (wr & (bus.address == ADDR_W'(BASE + int'(OFF_STATUS)))),
            .wr_control (wr & (bus.address == ADDR_W'(BASE + int'(OFF_CONTROL)))),
            .wr_period  (wr & (bus.address == ADDR_W'(BASE + int'(OFF_PERIOD)))),
            .wr_snap    (wr & (bus.address == ADDR_W'(BASE + int'(OFF_SNAP)))),
            .wdata      (bus.writedata[CNT_W-1:0]),
            .rd_off     (bus.address[1:0]),
            .rdata      (ch_rdata[c]),
            .pend       (pend[c])
        );
    end

`ifdef GEN2_MCTIMER_PRESCALER_EN
    logic                  wr_presc;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d, div_q, div_d;

    always_comb begin
        wr_presc    = wr & (bus.address == ADDR_W'(GLOB + 1));
        prescale_d  = wr_presc ? bus.writedata[PRESCALE_W-1:0] : prescale_q;
        tick        = div_q == prescale_q;
        div_d       = (wr_presc | tick) ? '0 : div_q + PRESCALE_W'(1);
        prescale_rd = 32'(prescale_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= '0;
            div_q      <= '0;
        end else begin
            prescale_q <= prescale_d;
            div_q      <= div_d;
        end
    end
`else
    assign tick        = 1'b1;
    assign prescale_rd = '0;
`endif

    always_comb begin
        rd_mux = (bus.address == ADDR_W'(GLOB))     ? 32'(pend) :
                 (bus.address == ADDR_W'(GLOB + 1)) ? prescale_rd : '0;
        for (int i = 0; i < NUM_CH; i++)
            rd_mux = (bus.address[ADDR_W-1:2] == (ADDR_W-2)'(i)) ? ch_rdata[i] : rd_mux;
        readdata_d = bus.chipselect ? rd_mux : '0;
        irq        = |pend;
    end

    always_ff @(posedge clk) begin
        if (reset) readdata_q <= '0;
        else       readdata_q <= readdata_d;
    end

    assign bus.readdata = readdata_q;
endmodule
